// File: rtl/i2c_slave.sv
// i2c_slave: single-address 7-bit I2C target. SCL/SDA are oversampled on clk,
// START/STOP and SCL edges are decoded from the synchronized copies, and SDA is
// driven open-drain (low or released). SCL is never driven (no clock stretching).
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       wr_valid,
  output logic       rd_req,
  output logic       rw,
  output logic       busy,
  output logic       done
);

  // Fewer than two synchronizer flops is never safe, so clamp the depth.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    WRITE,
    ACK_WR,
    READ,
    MACK,
    WAIT_STOP
  } state_t;

  logic [STAGES-1:0] sclSync_q;
  logic [STAGES-1:0] sdaSync_q;
  logic              sclPrev_q;
  logic              sdaPrev_q;
  logic [STAGES:0]   armed_q;

  state_t            state_q;
  logic [3:0]        bitCnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        rdLatch_q;
  logic              ackPhase_q;
  logic              mackOk_q;
  logic              sdaLow_q;
  logic [7:0]        dout_q;
  logic              wrValid_q;
  logic              rdReq_q;
  logic              rw_q;
  logic              busy_q;
  logic              done_q;

  logic              sclS;
  logic              sdaS;
  logic              armed;
  logic              sclRise;
  logic              sclFall;
  logic              startDet;
  logic              stopDet;
  logic [7:0]        shiftIn_d;

  assign sda      = sdaLow_q ? 1'b0 : 1'bz;
  assign dout     = dout_q;
  assign wr_valid = wrValid_q;
  assign rd_req   = rdReq_q;
  assign rw       = rw_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Synchronize the bus lines and keep a one-cycle history for edge decoding.
  // The armed chain masks the bogus edges seen while the synchronizers refill
  // after reset, so a reset in the middle of a transfer cannot fake a START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
      armed_q   <= '0;
    end else begin
      sclSync_q <= {sclSync_q[STAGES-2:0], scl};
      sdaSync_q <= {sdaSync_q[STAGES-2:0], sda};
      sclPrev_q <= sclSync_q[STAGES-1];
      sdaPrev_q <= sdaSync_q[STAGES-1];
      armed_q   <= {armed_q[STAGES-1:0], 1'b1};
    end
  end

  // Bus event decode; START/STOP require SCL high on both sides of the SDA edge.
  always_comb begin
    sclS      = sclSync_q[STAGES-1];
    sdaS      = sdaSync_q[STAGES-1];
    armed     = armed_q[STAGES];
    sclRise   = armed & sclS & ~sclPrev_q;
    sclFall   = armed & ~sclS & sclPrev_q;
    startDet  = armed & sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    stopDet   = armed & sclS & sclPrev_q & ~sdaPrev_q & sdaS;
    shiftIn_d = {shift_q[6:0], sdaS};
  end

  // Protocol FSM: START/STOP override everything, otherwise bits move on SCL
  // rises and SDA drive only changes after SCL falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= 4'd0;
      shift_q    <= 8'h00;
      rdLatch_q  <= 8'h00;
      ackPhase_q <= 1'b0;
      mackOk_q   <= 1'b0;
      sdaLow_q   <= 1'b0;
      dout_q     <= 8'h00;
      wrValid_q  <= 1'b0;
      rdReq_q    <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wrValid_q <= 1'b0;
      rdReq_q   <= 1'b0;
      done_q    <= 1'b0;
      if (rdReq_q) begin
        rdLatch_q <= din;
      end
      if (startDet) begin
        state_q  <= ADDR;
        bitCnt_q <= 4'd0;
        sdaLow_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (stopDet) begin
        state_q  <= IDLE;
        sdaLow_q <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= busy_q;
      end else begin
        case (state_q)
          IDLE: begin
            sdaLow_q <= 1'b0;
          end
          ADDR: begin
            if (sclRise) begin
              shift_q  <= shiftIn_d;
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd7) begin
                if (shiftIn_d[7:1] == SLAVE_ADDR) begin
                  rw_q       <= shiftIn_d[0];
                  busy_q     <= 1'b1;
                  ackPhase_q <= 1'b0;
                  state_q    <= ACK_ADDR;
                end else begin
                  state_q <= IDLE;
                end
              end
            end
          end
          ACK_ADDR: begin
            if (sclFall) begin
              if (!ackPhase_q) begin
                sdaLow_q   <= 1'b1;
                ackPhase_q <= 1'b1;
                rdReq_q    <= rw_q;
              end else if (rw_q) begin
                shift_q  <= rdLatch_q;
                sdaLow_q <= ~rdLatch_q[7];
                bitCnt_q <= 4'd1;
                state_q  <= READ;
              end else begin
                sdaLow_q <= 1'b0;
                bitCnt_q <= 4'd0;
                state_q  <= WRITE;
              end
            end
          end
          WRITE: begin
            if (sclRise) begin
              shift_q  <= shiftIn_d;
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd7) begin
                dout_q     <= shiftIn_d;
                wrValid_q  <= 1'b1;
                ackPhase_q <= 1'b0;
                state_q    <= ACK_WR;
              end
            end
          end
          ACK_WR: begin
            if (sclFall) begin
              if (!ackPhase_q) begin
                sdaLow_q   <= 1'b1;
                ackPhase_q <= 1'b1;
              end else begin
                sdaLow_q <= 1'b0;
                bitCnt_q <= 4'd0;
                state_q  <= WRITE;
              end
            end
          end
          READ: begin
            if (bitCnt_q == 4'd0) begin
              if (rdReq_q) begin
                shift_q  <= din;
                sdaLow_q <= ~din[7];
                bitCnt_q <= 4'd1;
              end
            end else if (sclFall) begin
              if (bitCnt_q == 4'd8) begin
                sdaLow_q <= 1'b0;
                mackOk_q <= 1'b0;
                state_q  <= MACK;
              end else begin
                sdaLow_q <= ~shift_q[3'd7 - bitCnt_q[2:0]];
                bitCnt_q <= bitCnt_q + 4'd1;
              end
            end
          end
          MACK: begin
            if (sclRise) begin
              if (!sdaS) begin
                mackOk_q <= 1'b1;
              end else begin
                state_q <= WAIT_STOP;
              end
            end else if (sclFall && mackOk_q) begin
              rdReq_q  <= 1'b1;
              bitCnt_q <= 4'd0;
              state_q  <= READ;
            end
          end
          WAIT_STOP: begin
            sdaLow_q <= 1'b0;
          end
          default: begin
            sdaLow_q <= 1'b0;
            state_q  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
